deserializer: RTL and testbench

- Receive-side counterpart of the serializer and sits directly downstream of it.
- Takes the MSB-first serial stream from ser_data_o / ser_data_val_o and reassembles it into MSB-aligned parallel words of a programmable length.
- Emits each word as a one-cycle valid pulse.
- If the serial stream stalls mid-word, flushes the partial word and marks it as an error.

---
 rtl/deserializer.sv | 164 ++++++++++++++++
 tb/tb_deserializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver. Collects an MSB-first bit stream into an
// MSB-aligned word whose length is picked with the first bit of each word.
// A stall inside a word longer than GAP_CYCLES flushes the partial word
// with the error flag set.
module deserializer #(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       ser_data_i,
    input  logic                       ser_data_val_i,
    input  logic [$clog2(WIDTH)-1:0]   len_i,
    output logic [WIDTH-1:0]           deser_data_o,
    output logic [$clog2(WIDTH):0]     deser_len_o,
    output logic                       deser_data_val_o,
    output logic                       deser_err_o,
    output logic                       busy_o
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CW-1:0] FULL_LEN  = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_LEN   = CW'(1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_CYCLES);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [GW-1:0]     gap_reg, gap_next;
    logic [WIDTH-1:0]  shift_reg, shift_next;
    logic [CW-1:0]     len_reg, len_next;
    logic [WIDTH-1:0]  data_reg, data_next;
    logic [CW-1:0]     dlen_reg, dlen_next;
    logic              err_reg, err_next;
    logic              val_reg, val_next;

    logic [WIDTH-1:0]  first_bit;
    logic [WIDTH-1:0]  placed_bit;
    logic [WIDTH-1:0]  shift_sum;
    logic [CW-1:0]     count_inc;
    logic [GW-1:0]     gap_inc;
    logic [CW-1:0]     target_len;

    // Incoming bit parked in the MSB, used for the first bit of a word
    assign first_bit = {ser_data_i, {(WIDTH-1){1'b0}}};

    // One-hot placement of the incoming bit at position WIDTH-1-count
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_place
            assign placed_bit[gi] = ser_data_i && (count_reg == CW'(WIDTH - 1 - gi));
        end
    endgenerate

    assign shift_sum  = shift_reg | placed_bit;
    assign count_inc  = count_reg + ONE_LEN;
    assign gap_inc    = gap_reg + GW'(1);
    assign target_len = (len_i == '0) ? FULL_LEN : {1'b0, len_i};

    // State and datapath registers; reset drops any word in flight
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_reg <= IDLE;
            count_reg <= '0;
            gap_reg   <= '0;
            shift_reg <= '0;
            len_reg   <= '0;
            data_reg  <= '0;
            dlen_reg  <= '0;
            err_reg   <= 1'b0;
            val_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            gap_reg   <= gap_next;
            shift_reg <= shift_next;
            len_reg   <= len_next;
            data_reg  <= data_next;
            dlen_reg  <= dlen_next;
            err_reg   <= err_next;
            val_reg   <= val_next;
        end
    end

    // Next-state logic: word assembly, completion and gap flush
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        gap_next   = gap_reg;
        shift_next = shift_reg;
        len_next   = len_reg;
        data_next  = data_reg;
        dlen_next  = dlen_reg;
        err_next   = err_reg;
        val_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ser_data_val_i) begin
                    len_next   = target_len;
                    shift_next = first_bit;
                    count_next = ONE_LEN;
                    gap_next   = '0;
                    if (target_len == ONE_LEN) begin
                        // Single-bit word finishes on its only bit
                        data_next  = first_bit;
                        dlen_next  = ONE_LEN;
                        err_next   = 1'b0;
                        val_next   = 1'b1;
                        count_next = '0;
                    end else begin
                        state_next = RECV;
                    end
                end
            end

            RECV: begin
                if (ser_data_val_i) begin
                    gap_next = '0;
                    if (count_inc == len_reg) begin
                        data_next  = shift_sum;
                        dlen_next  = len_reg;
                        err_next   = 1'b0;
                        val_next   = 1'b1;
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        shift_next = shift_sum;
                        count_next = count_inc;
                    end
                end else if (GAP_CYCLES > 0) begin
                    gap_next = (gap_reg == GAP_LIMIT) ? gap_reg : gap_inc;
                    if (gap_inc == GAP_LIMIT) begin
                        // Stream stalled too long: hand out what we have
                        data_next  = shift_reg;
                        dlen_next  = count_reg;
                        err_next   = 1'b1;
                        val_next   = 1'b1;
                        count_next = '0;
                        gap_next   = '0;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign deser_data_o     = data_reg;
    assign deser_len_o      = dlen_reg;
    assign deser_err_o      = err_reg;
    assign deser_data_val_o = val_reg;
    assign busy_o           = (state_reg == RECV);

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed table, hand-written corner sequences and
// randomized words checked against a transaction-level model.
module tb_deserializer;

    localparam int WIDTH = 16;
    localparam int GAP   = 4;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic        ser_data_i = 1'b0;
    logic        ser_data_val_i = 1'b0;
    logic [3:0]  len_i = 4'd0;
    logic [15:0] deser_data_o;
    logic [4:0]  deser_len_o;
    logic        deser_data_val_o;
    logic        deser_err_o;
    logic        busy_o;

    deserializer #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .len_i            (len_i),
        .deser_data_o     (deser_data_o),
        .deser_len_o      (deser_len_o),
        .deser_data_val_o (deser_data_val_o),
        .deser_err_o      (deser_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  len_in;
        logic [15:0] word;
        int          k;
        logic [15:0] exp_data;
        logic [4:0]  exp_len;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  len;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          edges  = 0;
    logic        mon_en = 1'b0;
    logic [15:0] hold_data = '0;
    logic [4:0]  hold_len  = '0;
    logic        hold_err  = 1'b0;

    always @(posedge clk_i) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Every pulse must match the head of the expectation queue, at its cycle;
    // between pulses the outputs must hold the last word.
    always @(negedge clk_i) begin
        if (mon_en && !srst_i) begin
            if (deser_data_val_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse actual data=%h len=%0d err=%0d required no pulse",
                             deser_data_o, deser_len_o, deser_err_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != edges || deser_data_o !== e.data ||
                        deser_len_o !== e.len || deser_err_o !== e.err) begin
                        errors++;
                        $display("FAIL pulse actual cyc=%0d data=%h len=%0d err=%0d required cyc=%0d data=%h len=%0d err=%0d",
                                 edges, deser_data_o, deser_len_o, deser_err_o,
                                 e.cyc, e.data, e.len, e.err);
                    end else begin
                        $display("pulse cyc=%0d data=%h len=%0d err=%0d ok", edges, e.data, e.len, e.err);
                    end
                    hold_data = e.data;
                    hold_len  = e.len;
                    hold_err  = e.err;
                end
            end else begin
                checks++;
                if (deser_data_o !== hold_data || deser_len_o !== hold_len || deser_err_o !== hold_err) begin
                    errors++;
                    $display("FAIL hold actual data=%h len=%0d err=%0d required data=%h len=%0d err=%0d",
                             deser_data_o, deser_len_o, deser_err_o, hold_data, hold_len, hold_err);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic [3:0] l);
        ser_data_val_i = v;
        ser_data_i     = b;
        len_i          = l;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom), 4'($urandom));
    endtask

    task automatic expect_pulse(input logic [15:0] d, input logic [4:0] l, input logic er);
        exp_t e;
        e.data = d;
        e.len  = l;
        e.err  = er;
        e.cyc  = edges;
        exp_q.push_back(e);
    endtask

    // Sends the top k bits of word with random short gaps; when a flush is
    // expected the word is abandoned with GAP idle cycles.
    task automatic send_word(input logic [3:0] len_in, input logic [15:0] word, input int k,
                             input int maxgap, input logic [15:0] ed, input logic [4:0] el,
                             input logic ee);
        int g;
        for (int i = 0; i < k; i++) begin
            if (i > 0 && maxgap > 0) begin
                g = $urandom_range(0, maxgap);
                repeat (g) idle();
            end
            drive(1'b1, word[15-i], (i == 0) ? len_in : 4'($urandom));
        end
        if (ee) repeat (GAP) idle();
        expect_pulse(ed, el, ee);
    endtask

    vec_t vecs[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd8,  16'hB200, 8,  16'hB200, 5'd8,  1'b0};
        vecs[1] = '{4'd0,  16'hA5C3, 16, 16'hA5C3, 5'd16, 1'b0};
        vecs[2] = '{4'd4,  16'h9000, 4,  16'h9000, 5'd4,  1'b0};
        vecs[3] = '{4'd4,  16'h6000, 4,  16'h6000, 5'd4,  1'b0};
        vecs[4] = '{4'd8,  16'hF800, 5,  16'hF800, 5'd5,  1'b1};
        vecs[5] = '{4'd1,  16'h8000, 1,  16'h8000, 5'd1,  1'b0};
        vecs[6] = '{4'd1,  16'h0000, 1,  16'h0000, 5'd1,  1'b0};
        vecs[7] = '{4'd15, 16'hFFFE, 15, 16'hFFFE, 5'd15, 1'b0};
        vecs[8] = '{4'd0,  16'hFFFF, 1,  16'h8000, 5'd1,  1'b1};
        vecs[9] = '{4'd3,  16'h4000, 3,  16'h4000, 5'd3,  1'b0};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_data",  32'(deser_data_o), 32'h0);
        chk("reset_len",   32'(deser_len_o), 32'h0);
        chk("reset_val",   32'(deser_data_val_o), 32'h0);
        chk("reset_err",   32'(deser_err_o), 32'h0);
        chk("reset_busy",  32'(busy_o), 32'h0);
        srst_i = 1'b0;
        mon_en = 1'b1;
        idle();
        idle();

        // Directed table, applied back to back
        for (int n = 0; n < 10; n++) begin
            send_word(vecs[n].len_in, vecs[n].word, vecs[n].k, 0,
                      vecs[n].exp_data, vecs[n].exp_len, vecs[n].exp_err);
        end
        idle();

        // Back-to-back 2-bit words: busy drops for the one completion cycle
        drive(1'b1, 1'b1, 4'd2);
        chk("b2b_busy_first", 32'(busy_o), 32'h1);
        drive(1'b1, 1'b0, 4'd7);
        expect_pulse(16'h8000, 5'd2, 1'b0);
        chk("b2b_busy_done", 32'(busy_o), 32'h0);
        chk("b2b_val_done",  32'(deser_data_val_o), 32'h1);
        drive(1'b1, 1'b1, 4'd2);
        chk("b2b_busy_next", 32'(busy_o), 32'h1);
        drive(1'b1, 1'b1, 4'd9);
        expect_pulse(16'hC000, 5'd2, 1'b0);
        idle();

        // Short gap is transparent
        drive(1'b1, 1'b1, 4'd8);
        drive(1'b1, 1'b1, 4'd3);
        drive(1'b1, 1'b0, 4'd3);
        idle();
        idle();
        chk("gap_busy", 32'(busy_o), 32'h1);
        drive(1'b1, 1'b1, 4'd2);
        drive(1'b1, 1'b0, 4'd2);
        drive(1'b1, 1'b1, 4'd2);
        drive(1'b1, 1'b0, 4'd2);
        drive(1'b1, 1'b1, 4'd2);
        expect_pulse(16'hD500, 5'd8, 1'b0);

        // Long gap flushes at the GAP-th idle edge
        drive(1'b1, 1'b1, 4'd8);
        repeat (4) drive(1'b1, 1'b1, 4'd1);
        repeat (GAP - 1) idle();
        chk("flush_not_yet", 32'(deser_data_val_o), 32'h0);
        chk("flush_busy",    32'(busy_o), 32'h1);
        idle();
        expect_pulse(16'hF800, 5'd5, 1'b1);
        chk("flush_busy_off", 32'(busy_o), 32'h0);
        idle();

        // Asynchronous reset in the middle of a word
        drive(1'b1, 1'b0, 4'd8);
        drive(1'b1, 1'b0, 4'd8);
        drive(1'b1, 1'b1, 4'd8);
        #1;
        srst_i    = 1'b1;
        hold_data = '0;
        hold_len  = '0;
        hold_err  = 1'b0;
        #1;
        chk("async_rst_data", 32'(deser_data_o), 32'h0);
        chk("async_rst_len",  32'(deser_len_o), 32'h0);
        chk("async_rst_err",  32'(deser_err_o), 32'h0);
        chk("async_rst_busy", 32'(busy_o), 32'h0);
        @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        send_word(4'd8, 16'h3C00, 8, 0, 16'h3C00, 5'd8, 1'b0);
        idle();

        // Randomized words against the transaction model
        for (int n = 0; n < 300; n++) begin
            int          L;
            int          k;
            logic [3:0]  len_in;
            logic [15:0] word;
            logic [15:0] ones;
            logic [15:0] ed;
            ones = 16'hFFFF;
            L = $urandom_range(1, 16);
            len_in = (L == 16) ? 4'd0 : 4'(L);
            word = 16'($urandom);
            k = L;
            if (L > 1 && $urandom_range(0, 3) == 0) k = $urandom_range(1, L - 1);
            ed = word & ~(ones >> k);
            repeat ($urandom_range(0, 5)) idle();
            send_word(len_in, word, k, GAP - 1, ed, 5'(k), (k < L));
        end

        repeat (8) idle();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
